vga_sync_receiver: RTL and testbench



---
 rtl/vga_sync_receiver.sv | 217 +++++++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: recovers x/y from hsync/vsync and qualifies lock.
// Define VGA_RX_MEASURE_EN to drive line_len/frame_lines, else both read 0.
module vga_sync_receiver #(
    parameter int HD          = 640,
    parameter int VD          = 480,
    parameter int HTOTAL      = 800,
    parameter int VTOTAL      = 525,
    parameter int HSYNC_START = 656,
    parameter int VSYNC_START = 513,
    parameter int LOCK_LINES  = 4,
    parameter int MISS_LIMIT  = 3,
    parameter int RUN_MAX     = 1023
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       p_tick,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       locked,
    output logic       frame_start,
    output logic       err,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines
);
    localparam logic [9:0] HD_L     = 10'(HD);
    localparam logic [9:0] VD_L     = 10'(VD);
    localparam logic [9:0] HTOT_L   = 10'(HTOTAL);
    localparam logic [9:0] VTOT_L   = 10'(VTOTAL);
    localparam logic [9:0] HMAX     = 10'(HTOTAL - 1);
    localparam logic [9:0] VMAX     = 10'(VTOTAL - 1);
    localparam logic [9:0] HS_L     = 10'(HSYNC_START);
    localparam logic [9:0] VS_L     = 10'(VSYNC_START);
    localparam logic [9:0] RUN_LAST = 10'(RUN_MAX);
    localparam logic [3:0] LOCK_LAST = 4'(LOCK_LINES - 1);
    localparam logic [3:0] MISS_LAST = 4'(MISS_LIMIT - 1);

    typedef enum logic [1:0] {SEARCH, LINE_OK, LOCKED} state_t;

    state_t     state;
    state_t     state_nx;
    logic [3:0] good_cnt;
    logic [3:0] good_nx;
    logic [3:0] miss_cnt;
    logic [3:0] miss_nx;
    logic       hs_meta;
    logic       hs_sync;
    logic       hs_prev;
    logic       vs_meta;
    logic       vs_sync;
    logic       vs_prev;
    logic [9:0] run;
    logic       run_valid;
    logic [9:0] line_cnt;
    logic       hs_rise;
    logic       vs_rise;
    logic       timeout;
    logic       len_ok;
    logic       good_line;
    logic       bad_line;
    logic       frame_ok;
    logic       reload;
    logic       err_nx;

    assign hs_rise   = p_tick & hs_sync & ~hs_prev;
    assign vs_rise   = p_tick & vs_sync & ~vs_prev;
    assign timeout   = p_tick & ~hs_rise & (run == RUN_LAST);
    assign len_ok    = (run == HTOT_L);
    // the first rise after reset or a timeout only opens a measurement
    assign good_line = hs_rise & run_valid & len_ok;
    assign bad_line  = (hs_rise & run_valid & ~len_ok) | timeout;
    assign frame_ok  = (line_cnt == VTOT_L);
    assign locked    = (state == LOCKED);
    assign video_on  = locked & (x < HD_L) & (y < VD_L);

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state    <= SEARCH;
            good_cnt <= '0;
            miss_cnt <= '0;
        end else begin
            state    <= state_nx;
            good_cnt <= good_nx;
            miss_cnt <= miss_nx;
        end
    end

    always_comb begin
        state_nx = state;
        good_nx  = good_cnt;
        miss_nx  = miss_cnt;
        err_nx   = 1'b0;
        reload   = 1'b0;
        unique case (state)
            SEARCH: begin
                reload = 1'b1;
                if (bad_line) begin
                    good_nx = '0;
                end else if (good_line) begin
                    if (good_cnt == LOCK_LAST) begin
                        state_nx = LINE_OK;
                        good_nx  = '0;
                    end else begin
                        good_nx = good_cnt + 4'd1;
                    end
                end
            end
            LINE_OK: begin
                reload = 1'b1;
                if (bad_line) begin
                    state_nx = SEARCH;
                    good_nx  = '0;
                end else if (vs_rise && frame_ok) begin
                    state_nx = LOCKED;
                    miss_nx  = '0;
                end
            end
            LOCKED: begin
                if (bad_line || (vs_rise && !frame_ok)) begin
                    err_nx = 1'b1;
                    if (miss_cnt == MISS_LAST) begin
                        state_nx = SEARCH;
                        miss_nx  = '0;
                    end else begin
                        miss_nx = miss_cnt + 4'd1;
                    end
                end else if (good_line) begin
                    miss_nx = '0;
                end
            end
            default: state_nx = SEARCH;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            hs_meta     <= 1'b0;
            hs_sync     <= 1'b0;
            hs_prev     <= 1'b0;
            vs_meta     <= 1'b0;
            vs_sync     <= 1'b0;
            vs_prev     <= 1'b0;
            run         <= '0;
            run_valid   <= 1'b0;
            line_cnt    <= '0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            err         <= 1'b0;
        end else begin
            hs_meta     <= hsync_in;
            hs_sync     <= hs_meta;
            vs_meta     <= vsync_in;
            vs_sync     <= vs_meta;
            err         <= err_nx;
            frame_start <= p_tick & locked & (x == HMAX) & (y == VMAX);
            if (p_tick) begin
                hs_prev <= hs_sync;
                vs_prev <= vs_sync;
                if (hs_rise) begin
                    run       <= 10'd1;
                    run_valid <= 1'b1;
                end else if (run == RUN_LAST) begin
                    run       <= 10'd1;
                    run_valid <= 1'b0;
                end else begin
                    run <= run + 10'd1;
                end
                if (vs_rise) begin
                    line_cnt <= hs_rise ? 10'd1 : 10'd0;
                end else if (hs_rise && line_cnt != 10'h3FF) begin
                    line_cnt <= line_cnt + 10'd1;
                end
                if (x == HMAX) begin
                    x <= '0;
                    y <= (y == VMAX) ? 10'd0 : y + 10'd1;
                end else begin
                    x <= x + 10'd1;
                end
                if (reload && hs_rise) begin
                    x <= HS_L;
                end
                if (reload && vs_rise) begin
                    y <= VS_L;
                end
            end
        end
    end

`ifdef VGA_RX_MEASURE_EN
    logic [9:0] line_len_q;
    logic [9:0] frame_lines_q;

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            line_len_q    <= '0;
            frame_lines_q <= '0;
        end else begin
            if (hs_rise) begin
                line_len_q <= run;
            end
            if (vs_rise) begin
                frame_lines_q <= line_cnt;
            end
        end
    end

    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
`else
    assign line_len    = '0;
    assign frame_lines = '0;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Scoreboard bench for vga_sync_receiver on a scaled-down raster.
module tb_vga_sync_receiver;
    localparam int HD   = 24;
    localparam int VD   = 10;
    localparam int HT   = 32;
    localparam int VT   = 14;
    localparam int HS   = 26;
    localparam int VS   = 11;
    localparam int RMAX = 40;
    localparam int FR   = HT * VT;
    localparam int T_RST = 6 * FR + 6 * HT + 16;
    localparam int T_END = 7 * FR + 12 * HT;

    logic       clk_100MHz = 1'b0;
    logic       reset      = 1'b0;
    logic       p_tick     = 1'b0;
    logic       hsync_in   = 1'b0;
    logic       vsync_in   = 1'b0;
    logic [9:0] x;
    logic [9:0] y;
    logic       video_on;
    logic       locked;
    logic       frame_start;
    logic       err;
    logic [9:0] line_len;
    logic [9:0] frame_lines;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       lk;
        logic       er;
        logic       fs;
        logic       vo;
        logic       xy;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    vga_sync_receiver #(
        .HD(HD), .VD(VD), .HTOTAL(HT), .VTOTAL(VT),
        .HSYNC_START(HS), .VSYNC_START(VS),
        .LOCK_LINES(4), .MISS_LIMIT(3), .RUN_MAX(RMAX)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .p_tick     (p_tick),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .x          (x),
        .y          (y),
        .video_on   (video_on),
        .locked     (locked),
        .frame_start(frame_start),
        .err        (err),
        .line_len   (line_len),
        .frame_lines(frame_lines)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic check_clear(input string ph);
        check({ph, "_x"}, x, 0);
        check({ph, "_y"}, y, 0);
        check({ph, "_vo"}, video_on, 0);
        check({ph, "_lk"}, locked, 0);
        check({ph, "_fs"}, frame_start, 0);
        check({ph, "_err"}, err, 0);
        check({ph, "_ll"}, line_len, 0);
        check({ph, "_fl"}, frame_lines, 0);
    endtask

    function automatic int at(input int f, input int yy, input int xx);
        return f * FR + yy * HT + xx;
    endfunction

    function automatic logic exp_lock(input int t);
        return (t >= at(1, 11, 0) && t < at(3, 7, 18)) ||
               (t >= at(5, 11, 0) && t < T_RST) ||
               (t >= at(7, 11, 0));
    endfunction

    function automatic logic exp_err(input int t);
        return t == at(2, 5, 2) || t == at(2, 11, 0) ||
               t == at(3, 5, 2) || t == at(3, 6, 10) ||
               t == at(3, 7, 18);
    endfunction

    // one pixel period: pins change just after a tick edge, sampled 4 clk later
    task automatic pix(input logic hs, input logic vs);
        hsync_in = hs;
        vsync_in = vs;
        repeat (3) @(posedge clk_100MHz);
        #1 p_tick = 1'b1;
        @(posedge clk_100MHz);
        #1 p_tick = 1'b0;
    endtask

    initial begin
        exp_t e;
        exp_t o;
        int   f;
        int   sy;
        int   sx;
        int   hlo;
        logic hs;
        logic vs;
        logic lk;
        logic lk_prev;

        repeat (3) @(posedge clk_100MHz);
        #1;
        check_clear("rst");
        reset = 1'b1;
        @(posedge clk_100MHz);
        #1;
        lk_prev = 1'b0;
        for (int t = 0; t < T_END; t++) begin
            if (t == T_RST) begin
                check("pre_rst_lk", locked, 1);
                reset = 1'b0;
                #1;
                check_clear("mid_rst");
                @(posedge clk_100MHz);
                #1 reset = 1'b1;
                lk_prev = 1'b0;
            end
            f   = t / FR;
            sy  = (t % FR) / HT;
            sx  = t % HT;
            hlo = (f == 4 && sy == 9) ? HS - 2 : HS;
            hs  = (sx >= hlo) && (sx < hlo + 4) &&
                  !(f == 2 && sy == 4) &&
                  !(f == 3 && sy >= 4 && sy <= 6);
            vs  = (sy >= VS) && (sy < VS + 2);
            lk  = exp_lock(t);
            e.x  = 10'(sx);
            e.y  = 10'(sy);
            e.lk = lk;
            e.er = exp_err(t);
            e.fs = lk_prev && sx == 0 && sy == 0;
            e.vo = lk && sx < HD && sy < VD;
            e.xy = (t >= at(0, 11, 0)) &&
                   !(f == 4 && (sy == 9 || sy == 10)) &&
                   !(t >= T_RST && t < at(6, 11, 0));
            sbq.push_back(e);
            pix(hs, vs);
            o = sbq.pop_front();
            if (o.xy) begin
                check($sformatf("x@%0d", t), x, o.x);
                check($sformatf("y@%0d", t), y, o.y);
            end
            check($sformatf("lk@%0d", t), locked, o.lk);
            check($sformatf("err@%0d", t), err, o.er);
            check($sformatf("fs@%0d", t), frame_start, o.fs);
            check($sformatf("vo@%0d", t), video_on, o.vo);
`ifdef VGA_RX_MEASURE_EN
            if (t == at(0, 2, 26) || t == at(5, 1, 26))
                check($sformatf("ll@%0d", t), line_len, HT);
            if (t == at(4, 9, 24))
                check("ll_short", line_len, HT - 2);
            if (t == at(4, 10, 26))
                check("ll_long", line_len, HT + 2);
            if (t == at(0, 11, 0))
                check("fl_f0", frame_lines, 11);
            if (t == at(1, 11, 0))
                check("fl_f1", frame_lines, VT);
            if (t == at(2, 11, 0))
                check("fl_f2", frame_lines, VT - 1);
`else
            check($sformatf("ll@%0d", t), line_len, 0);
            check($sformatf("fl@%0d", t), frame_lines, 0);
`endif
            lk_prev = lk;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
